// File: rtl/deadtime_monitor.sv
// deadtime_monitor: half-bridge gate-drive checker for shoot-through and short dead time
module deadtime_monitor #(
  parameter int MIN_DEAD = 30,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             highIn,
  input  logic             lowIn,
  input  logic             clr_fault,
  output logic             overlap_flt,
  output logic             dead_short_flt,
  output logic             fault,
  output logic             dead_vld,
  output logic [CNT_W-1:0] last_dead,
  output logic [CNT_W-1:0] min_dead,
  output logic [7:0]       flt_cnt
);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DEAD);
  typedef enum logic [1:0] {DEAD = 2'b00, ON_L = 2'b01, ON_H = 2'b10, OVERLAP = 2'b11} state_t;
  state_t st, nxt;
  logic h_q, l_q, armed, to_on, swap, rpt, ovl_hit, short_hit, any_hit;
  logic [CNT_W-1:0] cnt, rpt_val, min_base;
  always_comb begin
    nxt = state_t'({h_q, l_q});
    to_on = (nxt == ON_H || nxt == ON_L) && nxt != st;
    swap = (st == ON_H && nxt == ON_L) || (st == ON_L && nxt == ON_H);
    rpt = (st == DEAD && to_on) || swap;
    rpt_val = swap ? '0 : cnt;
    ovl_hit = nxt == OVERLAP && st != OVERLAP;
    short_hit = rpt && armed && rpt_val < MIN_V;
    any_hit = ovl_hit || short_hit;
    min_base = clr_fault ? '1 : min_dead;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= DEAD;
      cnt <= '0;
      armed <= 1'b0;
      h_q <= 1'b0;
      l_q <= 1'b0;
      overlap_flt <= 1'b0;
      dead_short_flt <= 1'b0;
      dead_vld <= 1'b0;
      last_dead <= '0;
      min_dead <= '1;
      flt_cnt <= '0;
    end else begin
      h_q <= highIn;
      l_q <= lowIn;
      st <= nxt;
      cnt <= nxt != DEAD ? cnt : st != DEAD ? CNT_W'(1) : &cnt ? cnt : cnt + 1'b1;
      armed <= armed | to_on;
      dead_vld <= rpt;
      last_dead <= rpt ? rpt_val : last_dead;
      min_dead <= rpt && armed && rpt_val < min_base ? rpt_val : min_base;
      overlap_flt <= ovl_hit | (overlap_flt & ~clr_fault);
      dead_short_flt <= short_hit | (dead_short_flt & ~clr_fault);
      flt_cnt <= clr_fault ? {7'd0, any_hit} : flt_cnt + {7'd0, any_hit & ~&flt_cnt};
    end
  end
  assign fault = overlap_flt | dead_short_flt;
endmodule
